// File: rtl/alu_seq.sv
// Registered ALU with start/done handshake and status flags.
// Optional shift-add multiplier compiled in when ALU_SEQ_MUL_EN is defined.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       inst,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sol,
  output logic             carry,
  output logic             zero,
  output logic             overflow
);

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;

  logic [WIDTH-1:0] sol_reg, sol_next;
  logic             carry_reg, carry_next;
  logic             zero_reg, zero_next;
  logic             ovf_reg, ovf_next;
  logic             done_reg, done_next;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_diff;
  logic [WIDTH-1:0] alu_sol;
  logic             alu_carry;
  logic             alu_ovf;
  logic             alu_commit;

  // Single-cycle result; alu_commit is low for opcodes that leave state untouched.
  always_comb begin
    add_sum    = {1'b0, operand_1} + {1'b0, operand_2};
    sub_diff   = {1'b0, operand_1} - {1'b0, operand_2};
    alu_sol    = '0;
    alu_carry  = 1'b0;
    alu_ovf    = 1'b0;
    alu_commit = 1'b1;
    case (inst)
      OP_ADD: begin
        alu_sol   = add_sum[WIDTH-1:0];
        alu_carry = add_sum[WIDTH];
        alu_ovf   = (operand_1[WIDTH-1] == operand_2[WIDTH-1]) &&
                    (add_sum[WIDTH-1] != operand_1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_sol   = sub_diff[WIDTH-1:0];
        alu_carry = sub_diff[WIDTH];
        alu_ovf   = (operand_1[WIDTH-1] != operand_2[WIDTH-1]) &&
                    (sub_diff[WIDTH-1] != operand_1[WIDTH-1]);
      end
      OP_AND:  alu_sol = operand_1 & operand_2;
      OP_OR:   alu_sol = operand_1 | operand_2;
      OP_XOR:  alu_sol = operand_1 ^ operand_2;
      default: alu_commit = 1'b0;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t             state_reg, state_next;
  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0]   mcand_reg, mcand_next;
  logic [WIDTH-1:0]   mplier_reg, mplier_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic [2*WIDTH-1:0] acc_step;

  // Partial product for the current multiplier bit, weighted by the iteration.
  assign acc_step = acc_reg + (mplier_reg[cnt_reg] ?
                    ({{WIDTH{1'b0}}, mcand_reg} << cnt_reg) : '0);

  always_comb begin
    sol_next    = sol_reg;
    carry_next  = carry_reg;
    zero_next   = zero_reg;
    ovf_next    = ovf_reg;
    done_next   = 1'b0;
    state_next  = state_reg;
    acc_next    = acc_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    cnt_next    = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          if (inst == OP_MUL) begin
            mcand_next  = operand_1;
            mplier_next = operand_2;
            acc_next    = '0;
            cnt_next    = '0;
            state_next  = S_MUL;
          end else begin
            done_next = 1'b1;
            if (alu_commit) begin
              sol_next   = alu_sol;
              carry_next = alu_carry;
              ovf_next   = alu_ovf;
              zero_next  = (alu_sol == '0);
            end
          end
        end
      end
      S_MUL: begin
        acc_next = acc_step;
        if (cnt_reg == CNT_LAST) begin
          sol_next   = acc_step[WIDTH-1:0];
          carry_next = (acc_step[2*WIDTH-1:WIDTH] != '0);
          ovf_next   = (acc_step[2*WIDTH-1:WIDTH] != '0);
          zero_next  = (acc_step[WIDTH-1:0] == '0);
          done_next  = 1'b1;
          cnt_next   = '0;
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      cnt_reg    <= cnt_next;
    end
  end

  assign busy = (state_reg == S_MUL);
`else
  // Without the multiplier every opcode completes in one cycle; 3'b110 acts as NOP.
  always_comb begin
    sol_next   = sol_reg;
    carry_next = carry_reg;
    zero_next  = zero_reg;
    ovf_next   = ovf_reg;
    done_next  = 1'b0;
    if (start) begin
      done_next = 1'b1;
      if (alu_commit) begin
        sol_next   = alu_sol;
        carry_next = alu_carry;
        ovf_next   = alu_ovf;
        zero_next  = (alu_sol == '0);
      end
    end
  end

  assign busy = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sol_reg   <= '0;
      carry_reg <= 1'b0;
      zero_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      sol_reg   <= sol_next;
      carry_reg <= carry_next;
      zero_reg  <= zero_next;
      ovf_reg   <= ovf_next;
      done_reg  <= done_next;
    end
  end

  assign sol      = sol_reg;
  assign carry    = carry_reg;
  assign zero     = zero_reg;
  assign overflow = ovf_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed test-plan cases plus random ops
// checked against an arithmetic reference model.
module tb_alu_seq;
  localparam int W = 8;
`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [2:0]   inst;
  logic [W-1:0] operand_1;
  logic [W-1:0] operand_2;
  logic         busy;
  logic         done;
  logic [W-1:0] sol;
  logic         carry;
  logic         zero;
  logic         overflow;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .inst(inst),
    .operand_1(operand_1), .operand_2(operand_2),
    .busy(busy), .done(done), .sol(sol),
    .carry(carry), .zero(zero), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int m_sol;
  bit m_carry, m_zero, m_ovf;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int to_signed(input int v);
    return (v >= 2 ** (W - 1)) ? v - 2 ** W : v;
  endfunction

  task automatic model_reset();
    m_sol = 0; m_carry = 0; m_zero = 0; m_ovf = 0;
  endtask

  // Expected result from plain integer arithmetic on the opcode table.
  task automatic model_apply(input logic [2:0] op, input int a, input int b);
    int r, s;
    bit upd;
    upd = 1'b1;
    case (op)
      3'b001: begin
        r = a + b; s = to_signed(a) + to_signed(b);
        m_carry = (r >= 2 ** W);
        m_ovf = (s > 2 ** (W - 1) - 1) || (s < -(2 ** (W - 1)));
        m_sol = r % (2 ** W);
      end
      3'b010: begin
        r = a - b; s = to_signed(a) - to_signed(b);
        m_carry = (a < b);
        m_ovf = (s > 2 ** (W - 1) - 1) || (s < -(2 ** (W - 1)));
        m_sol = (r + 2 ** W) % (2 ** W);
      end
      3'b011: begin m_sol = a & b; m_carry = 0; m_ovf = 0; end
      3'b100: begin m_sol = a | b; m_carry = 0; m_ovf = 0; end
      3'b101: begin m_sol = a ^ b; m_carry = 0; m_ovf = 0; end
      3'b110: begin
        if (MUL_EN) begin
          r = a * b;
          m_sol = r % (2 ** W);
          m_carry = (r >= 2 ** W);
          m_ovf = m_carry;
        end else upd = 1'b0;
      end
      default: upd = 1'b0;
    endcase
    if (upd) m_zero = (m_sol == 0);
  endtask

  task automatic check_result(input string tag);
    check_val({tag, "_sol"}, sol, m_sol);
    check_val({tag, "_carry"}, carry, m_carry);
    check_val({tag, "_zero"}, zero, m_zero);
    check_val({tag, "_ovf"}, overflow, m_ovf);
  endtask

  // Issues one request and checks timing and result; returns at the negedge
  // where done should be high.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit inject);
    bit is_mul;
    is_mul = MUL_EN && (op == 3'b110);
    @(negedge clk);
    check_val("done_idle", done, 0);
    start = 1'b1; inst = op; operand_1 = a; operand_2 = b;
    model_apply(op, int'(a), int'(b));
    @(negedge clk);
    start = 1'b0;
    inst = 3'($urandom); operand_1 = W'($urandom); operand_2 = W'($urandom);
    if (is_mul) begin
      for (int i = 0; i < W; i++) begin
        check_val("mul_busy", busy, 1);
        check_val("mul_done_early", done, 0);
        if (inject && i == 2) begin
          start = 1'b1; inst = 3'b001; operand_1 = 1; operand_2 = 1;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
      end
    end
    check_val("done", done, 1);
    check_val("busy_end", busy, 0);
    check_result("res");
    $display("op=%0d a=%0h b=%0h -> sol=%0h c=%0b z=%0b v=%0b", op, a, b, sol, carry, zero, overflow);
  endtask

  initial begin
    start = 0; inst = 0; operand_1 = 0; operand_2 = 0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_val("rst_sol", sol, 0);
    check_val("rst_carry", carry, 0);
    check_val("rst_zero", zero, 0);
    check_val("rst_ovf", overflow, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    rst_n = 1'b1;

    run_op(3'b001, 8'd200, 8'd100, 0);
    check_val("add_const", sol, 8'h2C);
    run_op(3'b010, 8'd5, 8'd7, 0);
    check_val("sub_const", sol, 8'hFE);
    run_op(3'b010, 8'h80, 8'h01, 0);
    check_val("sub_ovf_const", overflow, 1);
    run_op(3'b010, 8'h33, 8'h33, 0);
    check_val("sub_zero_const", zero, 1);
    run_op(3'b011, 8'hF0, 8'h3C, 0);
    run_op(3'b100, 8'hF0, 8'h3C, 0);
    run_op(3'b101, 8'hF0, 8'h3C, 0);
    check_val("xor_const", sol, 8'hCC);
    run_op(3'b000, 8'h12, 8'h34, 0);
    check_val("nop_hold", sol, 8'hCC);
    run_op(3'b111, 8'h00, 8'h00, 0);

    // MUL with an ignored ADD start mid-operation, then a start in the done cycle.
    run_op(3'b110, 8'd15, 8'd17, 1);
    start = 1'b1; inst = 3'b001; operand_1 = 1; operand_2 = 1;
    model_apply(3'b001, 1, 1);
    @(negedge clk);
    start = 1'b0;
    check_val("chain_done", done, 1);
    check_result("chain");
    run_op(3'b110, 8'd16, 8'd16, 0);

    // Reset in the middle of a MUL.
    run_op(3'b001, 8'd9, 8'd9, 0);
    @(negedge clk);
    start = 1'b1; inst = 3'b110; operand_1 = 8'd15; operand_2 = 8'd17;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_val("abort_busy", busy, 0);
    check_val("abort_done", done, 0);
    check_result("abort");
    repeat (2) @(negedge clk);
    check_val("abort_done_hold", done, 0);
    rst_n = 1'b1;
    run_op(3'b001, 8'd1, 8'd2, 0);

    for (int k = 0; k < 150; k++) begin
      run_op(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), ($urandom_range(0, 3) == 0));
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
